// File: rtl/gpu_spi_pkg.sv
// Shared types for the SPI command path: command entry layout and queue FSM states.
package gpu_spi_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 64;

  // One queued SPI transaction.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } state_t;

endpackage

// File: rtl/cmd_fifo_mem.sv
// Command FIFO storage: DEPTH x cmd_t register array, one write port, asynchronous read port.
module cmd_fifo_mem
  import gpu_spi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  cmd_t          wr_data,
  input  logic [PW-1:0] rd_addr,
  output cmd_t          rd_data
);

  cmd_t mem [DEPTH];

  // Write port; data array carries no reset, validity is tracked by the queue pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_cmd_queue.sv
// SPI transaction queue in front of the register file: FWFT command FIFO,
// blocking read handshake (one outstanding read), sticky overflow flag.
// Optional statistics (drop_count, high_water) enabled by macro SPI_CMD_QUEUE_STATS_EN.
module spi_cmd_queue
  import gpu_spi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  input  logic              in_rw,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              cmd_valid,
  output logic              cmd_rw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
`ifdef SPI_CMD_QUEUE_STATS_EN
  output logic [15:0]       drop_count,
  output logic [CW-1:0]     high_water,
`endif
  input  logic              ovf_clear
);

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] next_count;
  logic          push;
  logic          pop;
  logic          drop;
  logic          next_idle;
  cmd_t          wr_entry;
  cmd_t          head;

  // Admission is judged on the registered (pre-pop) full flag.
  assign push = in_valid & ~fifo_full;
  assign drop = in_valid & fifo_full;
  assign pop  = cmd_valid & cmd_ready;

  // FSM will sit in IDLE next cycle unless a read is popped now or a response is still awaited.
  assign next_idle = (state == ST_IDLE) ? ~(pop & cmd_rw) : rsp_valid;

  assign wr_entry  = '{rw: in_rw, addr: in_addr, data: in_wdata};
  assign cmd_rw    = head.rw;
  assign cmd_addr  = head.addr;
  assign cmd_wdata = head.data;

  cmd_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk    (sys_clk),
    .wr_en  (push),
    .wr_addr(wr_ptr),
    .wr_data(wr_entry),
    .rd_addr(rd_ptr),
    .rd_data(head)
  );

  // Occupancy after this cycle's push/pop.
  always_comb begin
    next_count = fifo_count;
    if (push && !pop)      next_count = fifo_count + CW'(1);
    else if (!push && pop) next_count = fifo_count - CW'(1);
  end

  // Pointers, count, status flags and head-valid, all registered from next-state values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      cmd_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= next_count;
      fifo_full  <= (next_count == CW'(DEPTH));
      fifo_empty <= (next_count == '0);
      cmd_valid  <= (next_count != '0) && next_idle;
    end
  end

  // Read handshake FSM; rdata only updates on a response that is actually awaited.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop && cmd_rw) state <= ST_WAIT_RSP;
        end
        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            rdata <= rsp_data;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)        overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (ovf_clear) overflow <= 1'b0;
  end

`ifdef SPI_CMD_QUEUE_STATS_EN
  // Saturating drop counter and occupancy high-water mark.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      drop_count <= '0;
      high_water <= '0;
    end else if (ovf_clear) begin
      drop_count <= drop ? 16'd1 : 16'd0;
      high_water <= '0;
    end else begin
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (next_count > high_water)          high_water <= next_count;
    end
  end
`endif

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Self-checking bench for spi_cmd_queue (DEPTH=16): vector table plus directed corner sequences.
module tb_spi_cmd_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid, in_rw;
  logic [6:0]  in_addr;
  logic [63:0] in_wdata;
  logic        cmd_valid, cmd_rw;
  logic [6:0]  cmd_addr;
  logic [63:0] cmd_wdata;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [63:0] rdata;
  logic [CW-1:0] fifo_count;
  logic        fifo_full, fifo_empty, overflow, ovf_clear;
`ifdef SPI_CMD_QUEUE_STATS_EN
  logic [15:0]   drop_count;
  logic [CW-1:0] high_water;
`endif

  int compared = 0;
  int mismatched = 0;

  spi_cmd_queue #(.DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_rw     (in_rw),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .cmd_valid (cmd_valid),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_ready (cmd_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rdata     (rdata),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .overflow  (overflow),
`ifdef SPI_CMD_QUEUE_STATS_EN
    .drop_count(drop_count),
    .high_water(high_water),
`endif
    .ovf_clear (ovf_clear)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        iv;
    logic        rw;
    logic [6:0]  addr;
    logic [63:0] wd;
    logic        rdy;
    logic        rv;
    logic [63:0] rd;
    logic        e_cv;
    logic [CW-1:0] e_cnt;
    logic        e_emp;
    logic        e_rw;
    logic [6:0]  e_addr;
    logic [63:0] e_wd;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic iv, logic rw, logic [6:0] addr, logic [63:0] wd,
                              logic rdy, logic rv, logic [63:0] rd,
                              logic e_cv, logic [CW-1:0] e_cnt, logic e_emp,
                              logic e_rw, logic [6:0] e_addr, logic [63:0] e_wd,
                              logic [63:0] e_rdata);
    vec_t v;
    v.iv = iv; v.rw = rw; v.addr = addr; v.wd = wd;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_cv = e_cv; v.e_cnt = e_cnt; v.e_emp = e_emp;
    v.e_rw = e_rw; v.e_addr = e_addr; v.e_wd = e_wd; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs already driven, sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_rw = 1'b0; in_addr = '0; in_wdata = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; ovf_clear = 1'b0;
  endtask

  localparam logic [63:0] D_WR  = 64'h1122334455667788;
  localparam logic [63:0] D_W2  = 64'hAA55AA55AA55AA55;
  localparam logic [63:0] D_RSP = 64'hDEADBEEFCAFEF00D;

  initial begin
    idle_inputs();
    sys_rst = 1'b1;

    // Basic write, then blocking read followed by a write.
    vecs[0]  = mk(1, 0, 7'h05, D_WR, 1, 0, '0,        1, 1, 0, 0, 7'h05, D_WR, '0);
    vecs[1]  = mk(0, 0, 7'h00, '0,   1, 0, '0,        0, 0, 1, 0, 7'h00, '0,   '0);
    vecs[2]  = mk(1, 1, 7'h10, '0,   0, 0, '0,        1, 1, 0, 1, 7'h10, '0,   '0);
    vecs[3]  = mk(1, 0, 7'h11, D_W2, 0, 0, '0,        1, 2, 0, 1, 7'h10, '0,   '0);
    vecs[4]  = mk(0, 0, 7'h00, '0,   1, 0, '0,        0, 1, 0, 0, 7'h00, '0,   '0);
    vecs[5]  = mk(0, 0, 7'h00, '0,   1, 0, '0,        0, 1, 0, 0, 7'h00, '0,   '0);
    vecs[6]  = mk(0, 0, 7'h00, '0,   1, 0, '0,        0, 1, 0, 0, 7'h00, '0,   '0);
    vecs[7]  = mk(0, 0, 7'h00, '0,   1, 0, '0,        0, 1, 0, 0, 7'h00, '0,   '0);
    vecs[8]  = mk(0, 0, 7'h00, '0,   1, 0, '0,        0, 1, 0, 0, 7'h00, '0,   '0);
    vecs[9]  = mk(0, 0, 7'h00, '0,   1, 1, D_RSP,     1, 1, 0, 0, 7'h11, D_W2, D_RSP);
    vecs[10] = mk(0, 0, 7'h00, '0,   1, 0, '0,        0, 0, 1, 0, 7'h00, '0,   D_RSP);
    vecs[11] = mk(0, 0, 7'h00, '0,   0, 1, 64'h1234,  0, 0, 1, 0, 7'h00, '0,   D_RSP);

    // Reset state.
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_count",     64'(fifo_count), 64'd0);
    chk("rst_empty",     64'(fifo_empty), 64'd1);
    chk("rst_full",      64'(fifo_full), 64'd0);
    chk("rst_overflow",  64'(overflow), 64'd0);
    chk("rst_rdata",     rdata, 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      in_valid = vecs[i].iv; in_rw = vecs[i].rw; in_addr = vecs[i].addr; in_wdata = vecs[i].wd;
      cmd_ready = vecs[i].rdy; rsp_valid = vecs[i].rv; rsp_data = vecs[i].rd;
      step();
      chk($sformatf("v%0d_cmd_valid", i), 64'(cmd_valid), 64'(vecs[i].e_cv));
      chk($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_empty", i), 64'(fifo_empty), 64'(vecs[i].e_emp));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d_cmd_rw", i), 64'(cmd_rw), 64'(vecs[i].e_rw));
        chk($sformatf("v%0d_cmd_addr", i), 64'(cmd_addr), 64'(vecs[i].e_addr));
        chk($sformatf("v%0d_cmd_wdata", i), cmd_wdata, vecs[i].e_wd);
      end
    end
    idle_inputs();

    // Fill to full with the head stalled, then overflow.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_rw = 1'b0; in_addr = 7'(i); in_wdata = 64'(i) * 64'h0101;
      step();
      chk($sformatf("fill%0d_count", i), 64'(fifo_count), 64'(i + 1));
    end
    chk("fill_full", 64'(fifo_full), 64'd1);
    chk("fill_overflow", 64'(overflow), 64'd0);
    in_addr = 7'h7F;
    step();
    chk("ovf_count", 64'(fifo_count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head_addr", 64'(cmd_addr), 64'h00);
    chk("ovf_cmd_valid", 64'(cmd_valid), 64'd1);
`ifdef SPI_CMD_QUEUE_STATS_EN
    chk("ovf_drop_count", 64'(drop_count), 64'd1);
    chk("ovf_high_water", 64'(high_water), 64'd16);
`endif
    in_addr = 7'h7E; ovf_clear = 1'b1;
    step();
    chk("ovf_set_wins", 64'(overflow), 64'd1);
    in_valid = 1'b0;
    step();
    chk("ovf_cleared", 64'(overflow), 64'd0);
`ifdef SPI_CMD_QUEUE_STATS_EN
    chk("ovf_drop_cleared", 64'(drop_count), 64'd0);
`endif
    ovf_clear = 1'b0;

    // Full queue: push and pop in the same cycle -> push dropped.
    in_valid = 1'b1; in_addr = 7'h7D; cmd_ready = 1'b1;
    step();
    chk("fullpop_count", 64'(fifo_count), 64'd15);
    chk("fullpop_full", 64'(fifo_full), 64'd0);
    chk("fullpop_overflow", 64'(overflow), 64'd1);
    in_valid = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), 64'(cmd_valid), 64'd1);
      chk($sformatf("drain%0d_addr", i), 64'(cmd_addr), 64'(i));
      chk($sformatf("drain%0d_wdata", i), cmd_wdata, 64'(i) * 64'h0101);
      step();
    end
    chk("drain_empty", 64'(fifo_empty), 64'd1);
    chk("drain_count", 64'(fifo_count), 64'd0);
    chk("drain_cmd_valid", 64'(cmd_valid), 64'd0);
    idle_inputs();

    // Reset while waiting for a read response with 3 entries queued.
    in_valid = 1'b1; in_rw = 1'b1; in_addr = 7'h20;
    step();
    in_rw = 1'b0;
    for (int i = 1; i < 4; i++) begin
      in_addr = 7'(8'h20 + i);
      step();
    end
    in_valid = 1'b0; cmd_ready = 1'b1;
    chk("wr_head_is_read", 64'(cmd_rw), 64'd1);
    step();
    chk("wr_count", 64'(fifo_count), 64'd3);
    chk("wr_cmd_valid", 64'(cmd_valid), 64'd0);
    #3 sys_rst = 1'b1;
    #1;
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_rdata", rdata, 64'd0);
    chk("midrst_empty", 64'(fifo_empty), 64'd1);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    idle_inputs();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    rsp_valid = 1'b1; rsp_data = 64'h5555AAAA5555AAAA;
    step();
    rsp_valid = 1'b0; rsp_data = '0;
    chk("late_rsp_rdata", rdata, 64'd0);
    chk("late_rsp_count", 64'(fifo_count), 64'd0);
    chk("late_rsp_cmd_valid", 64'(cmd_valid), 64'd0);
    in_valid = 1'b1; in_addr = 7'h33; in_wdata = 64'h33;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", 64'(cmd_valid), 64'd1);
    chk("post_rst_addr", 64'(cmd_addr), 64'h33);
    chk("post_rst_count", 64'(fifo_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
